// File: rtl/layer1_weight_seq_pkg.sv
// Shared definitions for the layer-1 weight sequencer.
// Contents:
//   - wseq_state_e      : sequencer FSM states.
//   - DEF_N1..DEF_N4    : default per-conv word counts, derived from the
//                         channel counts and kernel sizes of the block.
//   - seg_tag_t         : segment tag carried alongside each read.
//                         0 means no read; 1..4 name conv1..conv4.
//   - state_to_tag()    : issuing state to segment tag.
//   - tag_to_onehot()   : segment tag to one-hot valid vector.
package layer1_weight_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEG1  = 3'd1,
    ST_SEG2  = 3'd2,
    ST_SEG3  = 3'd3,
    ST_SEG4  = 3'd4,
    ST_DRAIN = 3'd5
  } wseq_state_e;

  localparam int CH_IN     = 64;
  localparam int CH_MID    = 64;
  localparam int CH_OUT    = 256;
  localparam int K_1X1     = 1;
  localparam int K_3X3     = 9;

  localparam int DEF_N1 = CH_IN  * CH_MID * K_1X1;  // conv1 1x1, 64->64
  localparam int DEF_N2 = CH_MID * CH_MID * K_3X3;  // conv2 3x3, 64->64
  localparam int DEF_N3 = CH_MID * CH_OUT * K_1X1;  // conv3 1x1, 64->256
  localparam int DEF_N4 = CH_IN  * CH_OUT * K_1X1;  // conv4 1x1 shortcut

  typedef logic [2:0] seg_tag_t;
  localparam seg_tag_t TAG_NONE = 3'd0;

  // Segment tag of a read issued from the given state.
  function automatic seg_tag_t state_to_tag(input wseq_state_e s);
    seg_tag_t t;
    case (s)
      ST_SEG1: t = 3'd1;
      ST_SEG2: t = 3'd2;
      ST_SEG3: t = 3'd3;
      ST_SEG4: t = 3'd4;
      default: t = TAG_NONE;
    endcase
    return t;
  endfunction

  // One-hot conv selector for a segment tag; zero when no read is tagged.
  function automatic logic [3:0] tag_to_onehot(input seg_tag_t t);
    logic [3:0] v;
    case (t)
      3'd1:    v = 4'b0001;
      3'd2:    v = 4'b0010;
      3'd3:    v = 4'b0100;
      3'd4:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wseq_seg_counter.sv
// Per-segment word counter for the weight sequencer.
// Ports:
//   clk, reset   : clock and synchronous active-high reset.
//   clear        : synchronous clear, holds the count at zero.
//   en           : advance by one word.
//   cnt_last     : last count value of the current segment.
//   cnt          : current count.
//   tc           : terminal count, high while cnt == cnt_last.
// Advancing at terminal count wraps to zero, ready for the next segment.
module wseq_seg_counter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_last,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;

  assign cnt = cnt_r;
  assign tc  = (cnt_r == cnt_last);

  // Word count register: clear, advance, or wrap at the segment end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (en) begin
      if (tc) begin
        cnt_r <= {WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/layer1_weight_seq.sv
// Layer-1 weight sequencer: streams the weights of four convolutions out
// of one contiguous weight memory and routes each word to its conv.
// Ports:
//   clk, reset        : clock and synchronous active-high reset.
//   start             : one-cycle request to load all four weight sets.
//   hold              : back-pressure; no new reads are issued while high.
//   rd_en, rd_addr    : weight-memory read request.
//   rd_data           : memory data, valid one cycle after rd_en.
//   weight_out        : weight word shared by all four conv ports.
//   valid_weight_out  : one-hot, bit k-1 qualifies weight_out for conv k.
//   busy              : high while a load is in progress.
//   done              : one-cycle pulse once the last word is delivered.
module layer1_weight_seq
  import layer1_weight_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int N1         = DEF_N1,
  parameter int N2         = DEF_N2,
  parameter int N3         = DEF_N3,
  parameter int N4         = DEF_N4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic [3:0]            valid_weight_out,
  output logic                  busy,
  output logic                  done
);

  localparam longint TOTAL_WORDS = longint'(N1) + longint'(N2)
                                 + longint'(N3) + longint'(N4);
  localparam longint ADDR_SPACE  = longint'(1) << ADDR_WIDTH;

  if (N1 < 1 || N2 < 1 || N3 < 1 || N4 < 1) begin : g_bad_seg_size
    $error("layer1_weight_seq: every segment needs at least one word");
  end
  if (TOTAL_WORDS > ADDR_SPACE) begin : g_bad_total
    $error("layer1_weight_seq: weight set does not fit the address space");
  end

  localparam logic [ADDR_WIDTH-1:0] BASE1 = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] BASE2 = ADDR_WIDTH'(N1);
  localparam logic [ADDR_WIDTH-1:0] BASE3 = ADDR_WIDTH'(N1 + N2);
  localparam logic [ADDR_WIDTH-1:0] BASE4 = ADDR_WIDTH'(N1 + N2 + N3);
  localparam logic [ADDR_WIDTH-1:0] LAST1 = ADDR_WIDTH'(N1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST2 = ADDR_WIDTH'(N2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST3 = ADDR_WIDTH'(N3 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST4 = ADDR_WIDTH'(N4 - 1);

  wseq_state_e           state_r;
  wseq_state_e           state_next_s;
  logic                  issue_s;
  logic                  done_s;
  logic [ADDR_WIDTH-1:0] seg_base_s;
  logic [ADDR_WIDTH-1:0] seg_last_s;
  logic [ADDR_WIDTH-1:0] cnt_s;
  logic                  tc_s;
  logic                  cnt_clear_s;
  logic                  pipe_empty_s;
  seg_tag_t              tag_s1_r;
  logic [DATA_WIDTH-1:0] weight_r;
  logic [3:0]            valid_r;

  assign cnt_clear_s  = (state_r == ST_IDLE);
  // Empty once no tag waits for its data and no word is on the outputs.
  assign pipe_empty_s = (tag_s1_r == TAG_NONE) && (valid_r == 4'b0000);

  wseq_seg_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_seg_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .en       (issue_s),
    .cnt_last (seg_last_s),
    .cnt      (cnt_s),
    .tc       (tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, read issue and segment window selection.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    done_s       = 1'b0;
    seg_base_s   = {ADDR_WIDTH{1'b0}};
    seg_last_s   = {ADDR_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SEG1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEG1, ST_SEG2, ST_SEG3, ST_SEG4: begin
        case (state_r)
          ST_SEG1: begin seg_base_s = BASE1; seg_last_s = LAST1; end
          ST_SEG2: begin seg_base_s = BASE2; seg_last_s = LAST2; end
          ST_SEG3: begin seg_base_s = BASE3; seg_last_s = LAST3; end
          ST_SEG4: begin seg_base_s = BASE4; seg_last_s = LAST4; end
          default: begin seg_base_s = BASE1; seg_last_s = LAST1; end
        endcase
        if (!hold) begin
          issue_s = 1'b1;
          if (tc_s) begin
            case (state_r)
              ST_SEG1: state_next_s = ST_SEG2;
              ST_SEG2: state_next_s = ST_SEG3;
              ST_SEG3: state_next_s = ST_SEG4;
              default: state_next_s = ST_DRAIN;
            endcase
          end else begin
            state_next_s = state_r;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Delivery pipeline: the tag rides one stage while memory answers, then
  // the returned word and its one-hot route are registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s1_r <= TAG_NONE;
      weight_r <= {DATA_WIDTH{1'b0}};
      valid_r  <= 4'b0000;
    end else begin
      tag_s1_r <= issue_s ? state_to_tag(state_r) : TAG_NONE;
      valid_r  <= tag_to_onehot(tag_s1_r);
      if (tag_s1_r != TAG_NONE) begin
        weight_r <= rd_data;
      end
    end
  end

  assign rd_en            = issue_s;
  assign rd_addr          = seg_base_s + cnt_s;
  assign weight_out       = weight_r;
  assign valid_weight_out = valid_r;
  assign busy             = (state_r != ST_IDLE);
  assign done             = done_s;

endmodule

// File: tb/tb_layer1_weight_seq.sv
// Directed bench for layer1_weight_seq with segment sizes 2/3/2/2.
// Memory returns address+100 one cycle after each read.
module tb_layer1_weight_seq;

  localparam int DW = 32;
  localparam int AW = 17;
  localparam int NW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = 32'd0;
  logic [DW-1:0] weight_out;
  logic [3:0]    valid_weight_out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0;

  int iss_addr[$];
  int iss_cyc[$];
  int dv_w[$];
  int dv_v[$];
  int dv_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  logic [3:0] exp_v [NW] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                             4'b0100, 4'b0100, 4'b1000, 4'b1000};

  layer1_weight_seq #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N1 (2), .N2 (3), .N3 (2), .N4 (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .hold             (hold),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .weight_out       (weight_out),
    .valid_weight_out (valid_weight_out),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, data = address + 100.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 32'(rd_addr) + 32'd100;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observation of issues, deliveries and done pulses, mid-cycle.
  always @(negedge clk) begin
    if (rd_en) begin
      iss_addr.push_back(int'(rd_addr));
      iss_cyc.push_back(cyc);
    end
    if (valid_weight_out != 4'b0000) begin
      dv_w.push_back(int'(weight_out));
      dv_v.push_back(int'(valid_weight_out));
      dv_cyc.push_back(cyc);
      check_val("onehot", $countones(valid_weight_out), 1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    iss_addr.delete(); iss_cyc.delete();
    dv_w.delete(); dv_v.delete(); dv_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      step();
    end
    if (done_cnt == 0) check_val("done_timeout", 0, 1);
    repeat (4) step();
  endtask

  task automatic check_load(input string nm);
    check_val({nm, "_nissue"}, iss_addr.size(), NW);
    check_val({nm, "_ndeliv"}, dv_w.size(), NW);
    check_val({nm, "_ndone"}, done_cnt, 1);
    for (int i = 0; i < NW; i++) begin
      if (i < iss_addr.size()) check_val({nm, "_addr"}, iss_addr[i], i);
      if (i < dv_w.size()) begin
        check_val({nm, "_weight"}, dv_w[i], 100 + i);
        check_val({nm, "_route"}, dv_v[i], int'(exp_v[i]));
      end
      if (i < iss_cyc.size() && i < dv_cyc.size())
        check_val({nm, "_latency"}, dv_cyc[i] - iss_cyc[i], 2);
    end
    if (dv_cyc.size() == NW && done_cnt > 0)
      check_val({nm, "_done_time"}, done_cyc - dv_cyc[NW-1], 1);
    check_val({nm, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    // Reset, with start held high during reset.
    reset = 1'b1; start = 1'b1; hold = 1'b0;
    step(); step();
    @(negedge clk);
    check_val("rst_rd_en", int'(rd_en), 0);
    check_val("rst_rd_addr", int'(rd_addr), 0);
    check_val("rst_weight", int'(weight_out), 0);
    check_val("rst_valid", int'(valid_weight_out), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    step();
    reset = 1'b0; start = 1'b0;
    clear_q();
    repeat (4) step();
    check_val("rst_start_ignored_busy", int'(busy), 0);
    check_val("rst_start_ignored_iss", iss_addr.size(), 0);

    // Test 1: plain load.
    clear_q();
    start = 1'b1; c0 = cyc;
    step(); start = 1'b0;
    wait_done(60);
    check_load("t1");
    if (iss_cyc.size() > 0) check_val("t1_first_issue", iss_cyc[0] - c0, 1);
    for (int i = 1; i < iss_cyc.size(); i++)
      check_val("t1_contig", iss_cyc[i] - iss_cyc[0], i);
    check_val("t1_weight_holds", int'(weight_out), 108);

    // Test 2: hold for 3 cycles in SEG2, frozen at address 3.
    clear_q();
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    hold = 1'b1;
    @(negedge clk);
    check_val("t2_hold_rd_en", int'(rd_en), 0);
    check_val("t2_hold_addr", int'(rd_addr), 3);
    step(); step(); step();
    hold = 1'b0;
    wait_done(60);
    check_load("t2");
    if (iss_cyc.size() >= 4) check_val("t2_gap", iss_cyc[3] - iss_cyc[2], 4);

    // Test 3: second start while busy is ignored.
    clear_q();
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    start = 1'b1;
    step(); start = 1'b0;
    wait_done(60);
    check_load("t3");

    // Test 4: reset after 4 reads, then a clean reload.
    clear_q();
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_q();
    @(negedge clk);
    check_val("t4_rd_en", int'(rd_en), 0);
    check_val("t4_rd_addr", int'(rd_addr), 0);
    check_val("t4_weight", int'(weight_out), 0);
    check_val("t4_valid", int'(valid_weight_out), 0);
    check_val("t4_busy", int'(busy), 0);
    check_val("t4_done", int'(done), 0);
    repeat (8) step();
    check_val("t4_no_deliv", dv_w.size(), 0);
    check_val("t4_no_issue", iss_addr.size(), 0);
    check_val("t4_no_done", done_cnt, 0);

    clear_q();
    start = 1'b1;
    step(); start = 1'b0;
    wait_done(60);
    check_load("t5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
